// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package rv_fetch_pkg;

   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_FULL  = 3'd3,
      ST_DRAIN = 3'd4
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } if_payload_t;

   function automatic logic [31:0] pc_plus4(input logic [31:0] p);
      return p + 32'd4;
   endfunction

endpackage

// File: rtl/if_skid_buf.sv
// rtl/if_skid_buf.sv - one-entry holding register for a fetched {instr, pc} pair
module if_skid_buf
   import rv_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        clear,
   input  if_payload_t din,
   output logic        valid,
   output if_payload_t dout
);

   // clear wins over load so a flush always discards the held word
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         valid <= 1'b0;
         dout  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         dout  <= din;
      end
   end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: single outstanding imem request into the IF/ID register
module if_stage
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_INSTR = RV_NOP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic        pc_advance,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        id_stall,
   input  logic        flush,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_4
);

   fetch_state_t state, state_next;
   logic         accept_rsp;
   logic         skid_load;
   logic         skid_release;
   logic         skid_valid;
   if_payload_t  skid_din;
   if_payload_t  skid_dout;

   assign imem_addr = {pc[31:2], 2'b00};
   assign skid_din  = {imem_rdata, pc};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      imem_req     = 1'b0;
      pc_advance   = 1'b0;
      accept_rsp   = 1'b0;
      skid_load    = 1'b0;
      skid_release = 1'b0;
      case (state)
         ST_IDLE: begin
            state_next = ST_REQ;
         end
         ST_REQ: begin
            if (!flush) begin
               imem_req   = 1'b1;
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // pc is still the request address here: it only moves on pc_advance
            if (flush) begin
               state_next = imem_rvalid ? ST_REQ : ST_DRAIN;
            end else if (imem_rvalid) begin
               if (!id_stall || !id_valid) begin
                  accept_rsp = 1'b1;
                  pc_advance = 1'b1;
                  state_next = ST_REQ;
               end else begin
                  skid_load  = 1'b1;
                  state_next = ST_FULL;
               end
            end
         end
         ST_FULL: begin
            if (flush || !skid_valid) begin
               state_next = ST_REQ;
            end else if (!id_stall) begin
               skid_release = 1'b1;
               pc_advance   = 1'b1;
               state_next   = ST_REQ;
            end
         end
         ST_DRAIN: begin
            if (imem_rvalid) begin
               state_next = ST_REQ;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      if (rst) begin
         imem_req     = 1'b0;
         pc_advance   = 1'b0;
         accept_rsp   = 1'b0;
         skid_load    = 1'b0;
         skid_release = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         id_valid <= 1'b0;
         id_instr <= RESET_INSTR;
         id_pc    <= '0;
         id_pc_4  <= '0;
      end else if (flush) begin
         id_valid <= 1'b0;
         id_instr <= RESET_INSTR;
      end else if (accept_rsp) begin
         id_valid <= 1'b1;
         id_instr <= imem_rdata;
         id_pc    <= pc;
         id_pc_4  <= pc_plus4(pc);
      end else if (skid_release) begin
         id_valid <= 1'b1;
         id_instr <= skid_dout.instr;
         id_pc    <= skid_dout.pc;
         id_pc_4  <= pc_plus4(skid_dout.pc);
      end else if (!id_stall) begin
         id_valid <= 1'b0;
      end
   end

   if_skid_buf u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .clear (flush || skid_release),
      .din   (skid_din),
      .valid (skid_valid),
      .dout  (skid_dout)
   );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed scoreboard bench for if_stage with a PC-register and imem model
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        id_stall;
   logic        imem_rvalid;
   logic [31:0] pc;
   logic [31:0] imem_rdata;
   logic        pc_advance;
   logic        imem_req;
   logic        id_valid;
   logic [31:0] imem_addr;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_4;

   if_stage dut (
      .clk         (clk),
      .rst         (rst),
      .pc          (pc),
      .pc_advance  (pc_advance),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .id_stall    (id_stall),
      .flush       (flush),
      .id_valid    (id_valid),
      .id_instr    (id_instr),
      .id_pc       (id_pc),
      .id_pc_4     (id_pc_4)
   );

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc;
   int          lat;
   int          mem_cnt;
   int          req_count;
   int          adv_count;
   int          last_req_cyc;
   int          last_adv_cyc;
   int          base_adv;
   int          prev_req;
   bit          mem_pend;
   bit          obs_req;
   bit          obs_adv;
   logic [31:0] mem_addr;
   logic [31:0] redirect;
   logic [31:0] last_req_addr;
   exp_t        exp_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $fatal(1, "FAIL watchdog: simulation did not reach the summary");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return {a[19:0], 12'h113};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Combinational outputs are sampled mid-cycle; models and inputs update 1 time unit after the edge.
   task automatic tick();
      @(negedge clk);
      obs_req = imem_req;
      obs_adv = pc_advance;
      if (imem_req) begin
         chk("one_outstanding", {31'd0, mem_pend}, 32'd0);
         mem_pend      = 1'b1;
         mem_cnt       = lat;
         mem_addr      = imem_addr;
         req_count++;
         last_req_cyc  = cyc;
         last_req_addr = imem_addr;
      end
      if (pc_advance) begin
         adv_count++;
         last_adv_cyc = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rst)          pc = 32'h0;
      else if (flush)   pc = redirect;
      else if (obs_adv) pc = pc + 32'd4;
      imem_rvalid = 1'b0;
      if (mem_pend) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr);
            mem_pend    = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      flush       = 1'b0;
      id_stall    = 1'b0;
      imem_rvalid = 1'b0;
      mem_pend    = 1'b0;
      exp_q.delete();
      tick();
      tick();
      rst           = 1'b0;
      cyc           = 0;
      req_count     = 0;
      adv_count     = 0;
      last_req_cyc  = -1;
      last_adv_cyc  = -1;
      last_req_addr = 32'hFFFF_FFFF;
   endtask

   task automatic expect_load(input logic [31:0] p);
      exp_t e;
      e.instr = mem_word(p);
      e.pc    = p;
      e.pc4   = p + 32'd4;
      exp_q.push_back(e);
   endtask

   task automatic wait_load(input string tag, input int budget);
      exp_t e;
      int   n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!obs_adv && n < budget);
      chk($sformatf("%s.adv", tag), {31'd0, obs_adv}, 32'd1);
      chk($sformatf("%s.queue", tag), {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (obs_adv) begin
            chk($sformatf("%s.valid", tag), {31'd0, id_valid}, 32'd1);
            chk($sformatf("%s.instr", tag), id_instr, e.instr);
            chk($sformatf("%s.pc", tag), id_pc, e.pc);
            chk($sformatf("%s.pc_4", tag), id_pc_4, e.pc4);
         end
      end
   endtask

   initial begin
      pc         = 32'h0;
      imem_rdata = 32'h0;
      redirect   = 32'h0;
      mem_addr   = 32'h0;
      mem_cnt    = 0;
      lat        = 1;
      cyc        = 0;

      // reset values, then L=1 first fetch
      do_reset();
      chk("rst.id_valid", {31'd0, id_valid}, 32'd0);
      chk("rst.id_instr", id_instr, NOP);
      chk("rst.id_pc", id_pc, 32'h0);
      chk("rst.id_pc_4", id_pc_4, 32'h0);
      chk("rst.imem_req", {31'd0, imem_req}, 32'd0);
      chk("rst.pc_advance", {31'd0, pc_advance}, 32'd0);
      expect_load(32'h0);
      tick();
      tick();
      chk("t1.req_cyc", last_req_cyc, 32'd1);
      chk("t1.req_addr", last_req_addr, 32'h0);
      wait_load("t1", 20);
      chk("t1.adv_cyc", last_adv_cyc, 32'd2);
      chk("t1.load_cyc", cyc, 32'd3);
      chk("t1.adv_count", adv_count, 32'd1);
      tick();
      chk("t1.consumed", {31'd0, id_valid}, 32'd0);

      // L=3, four sequential fetches
      do_reset();
      lat = 3;
      for (int k = 0; k < 4; k++) expect_load(k * 4);
      prev_req = 0;
      for (int k = 0; k < 4; k++) begin
         wait_load($sformatf("t2.i%0d", k), 20);
         chk($sformatf("t2.req_addr%0d", k), last_req_addr, k * 4);
         if (k > 0) chk($sformatf("t2.spacing%0d", k), last_req_cyc - prev_req, 32'd4);
         prev_req = last_req_cyc;
      end
      chk("t2.req_count", req_count, 32'd4);
      chk("t2.adv_count", adv_count, 32'd4);

      // decode stall while the response lands: skid, then release
      id_stall = 1'b1;
      base_adv = adv_count;
      repeat (5) tick();
      chk("t3.adv_held", adv_count, base_adv);
      chk("t3.hold_valid", {31'd0, id_valid}, 32'd1);
      chk("t3.hold_pc", id_pc, 32'hC);
      chk("t3.hold_instr", id_instr, mem_word(32'hC));
      chk("t3.req_count", req_count, 32'd5);
      id_stall = 1'b0;
      expect_load(32'h10);
      wait_load("t3", 1);
      chk("t3.adv_once", adv_count, base_adv + 1);
      tick();
      chk("t3.next_req_cyc", last_req_cyc, cyc - 1);
      chk("t3.next_addr", last_req_addr, 32'h14);

      // flush in WAIT, L=2: drain the stale response, refetch at 0x40
      do_reset();
      lat = 2;
      tick();
      tick();
      flush    = 1'b1;
      redirect = 32'h40;
      tick();
      flush = 1'b0;
      chk("t4.flush_adv", {31'd0, obs_adv}, 32'd0);
      chk("t4.flush_valid", {31'd0, id_valid}, 32'd0);
      chk("t4.flush_instr", id_instr, NOP);
      tick();
      chk("t4.drain_adv", {31'd0, obs_adv}, 32'd0);
      chk("t4.drain_req", {31'd0, obs_req}, 32'd0);
      chk("t4.drain_valid", {31'd0, id_valid}, 32'd0);
      tick();
      chk("t4.req_cyc", last_req_cyc, 32'd4);
      chk("t4.req_addr", last_req_addr, 32'h40);
      expect_load(32'h40);
      wait_load("t4", 20);

      // flush coincident with imem_rvalid
      tick();
      tick();
      flush    = 1'b1;
      redirect = 32'h80;
      tick();
      flush = 1'b0;
      chk("t5a.adv", {31'd0, obs_adv}, 32'd0);
      chk("t5a.valid", {31'd0, id_valid}, 32'd0);
      chk("t5a.instr", id_instr, NOP);
      tick();
      chk("t5a.req_cyc", last_req_cyc, cyc - 1);
      chk("t5a.req_addr", last_req_addr, 32'h80);

      // flush in FULL, redirect to the top of the address space
      expect_load(32'h80);
      wait_load("t5b.pre", 20);
      id_stall = 1'b1;
      tick();
      tick();
      tick();
      chk("t5b.full_hold", id_pc, 32'h80);
      flush    = 1'b1;
      redirect = 32'hFFFF_FFFC;
      tick();
      flush    = 1'b0;
      id_stall = 1'b0;
      chk("t5b.adv", {31'd0, obs_adv}, 32'd0);
      chk("t5b.valid", {31'd0, id_valid}, 32'd0);
      chk("t5b.instr", id_instr, NOP);
      tick();
      chk("t5b.req_cyc", last_req_cyc, cyc - 1);
      chk("t5b.req_addr", last_req_addr, 32'hFFFF_FFFC);
      expect_load(32'hFFFF_FFFC);
      wait_load("t5b.wrap", 20);

      // reset during WAIT, stale response right after release
      tick();
      do_reset();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      chk("t6.rst_valid", {31'd0, id_valid}, 32'd0);
      chk("t6.rst_instr", id_instr, NOP);
      chk("t6.rst_pc", id_pc, 32'h0);
      chk("t6.rst_pc_4", id_pc_4, 32'h0);
      tick();
      chk("t6.stale_adv", {31'd0, obs_adv}, 32'd0);
      chk("t6.stale_req", {31'd0, obs_req}, 32'd0);
      chk("t6.stale_valid", {31'd0, id_valid}, 32'd0);
      tick();
      chk("t6.req_cyc", last_req_cyc, 32'd1);
      chk("t6.req_addr", last_req_addr, 32'h0);
      expect_load(32'h0);
      wait_load("t6", 20);
      chk("t6.adv_count", adv_count, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the RISC-V PHZ core, directly downstream of the PC register. Takes the current PC and issues a single outstanding request to instruction memory. It captures the returned word into the IF/ID pipeline register and drives the PC register's advance input (its `stall_sel`). It absorbs variable memory latency, decode back-pressure and branch flushes without losing or duplicating an instruction.

## Interface
- `RESET_INSTR`, default 32'h0000_0013: `id_instr` value on reset and after a flush (NOP: `addi x0,x0,0`).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `pc`  in  32  current PC from the PC register. Bits [1:0] are already zero.
- `pc_advance`  out  1  to PC register `stall_sel`. 1 = load pc+4 at the next edge; 0 = hold.
- `imem_req`  out  1  single-cycle request pulse.
- `imem_addr`  out  32  equals {pc[31:2],2'b00}. Valid while `imem_req`=1.
- `imem_rvalid`  in  1  single-cycle response pulse. Arrives ≥1 cycle after `imem_req`.
- `imem_rdata`  in  32  instruction word. Valid with `imem_rvalid`.
- `id_stall`  in  1  decode cannot accept a new IF/ID value this cycle.
- `flush`  in  1  branch/jump taken. Same cycle the PC register sees `pc_sel`=1.
- `id_valid`  out  1  IF/ID holds a valid instruction.
- `id_instr`  out  32  IF/ID instruction.
- `id_pc`  out  32  address of `id_instr`.
- `id_pc_4`  out  32  `id_pc`+4, registered, mod 2^32.

## Operation
- FSM states: IDLE, REQ, WAIT, FULL, DRAIN.
- IDLE: entered on reset. Goes to REQ next cycle. Any `imem_rvalid` is ignored.
- REQ: `imem_req` = !`flush`, `imem_addr` from `pc`. Without flush → WAIT. With flush → stay in REQ, no request issued.
- WAIT, on `imem_rvalid`, if `id_stall`=0 or `id_valid`=0 (accept):
  - load IF/ID with {`imem_rdata`, `pc`, `pc`+4}; set `id_valid`=1;
  - `pc_advance`=1 this cycle; → REQ.
- WAIT, on `imem_rvalid`, if `id_stall`=1 and `id_valid`=1:
  - store {`imem_rdata`, `pc`} in the skid buffer; → FULL.
  - `pc_advance` stays 0.
- FULL: when `id_stall`=0, move the skid buffer into IF/ID, `pc_advance`=1, → REQ.
- Decode consumes: `id_stall`=0 with no new instruction loaded clears `id_valid` to 0.
- `pc_advance` is combinational (`imem_rvalid`/`id_stall` → `pc_advance`) and is 1 only in the cycle an instruction enters IF/ID.
- Flush has priority over everything:
  - `id_valid`←0, `id_instr`←`RESET_INSTR`;
  - skid buffer discarded; `pc_advance`=0.
- Flush next state:
  - in WAIT without `imem_rvalid` → DRAIN;
  - in WAIT with `imem_rvalid` in the same cycle → response dropped, → REQ;
  - in FULL or IDLE → REQ.
- DRAIN: wait for `imem_rvalid`, discard it, → REQ. A further `flush` in DRAIN stays in DRAIN.
- Never more than one outstanding request. Never a request outside REQ.

## Timing
- Reset values: state IDLE, `id_valid`=0, `id_instr`=`RESET_INSTR`, `id_pc`=0, `id_pc_4`=0, `imem_req`=0, `pc_advance`=0, skid buffer empty.
- Reset mid-operation abandons any outstanding request. A stale `imem_rvalid` after reset is dropped (arrives in IDLE/REQ).
- Fetch latency: REQ at cycle t. `imem_rvalid` at t+L (L≥1). IF/ID valid at t+L+1. Next REQ at t+L+1.
- Throughput: one instruction per L+1 cycles.
- After flush at cycle t, the first REQ uses the redirected `pc` no earlier than t+1.

## Structure
- Package `rv_fetch_pkg` holds:
  - FSM state encoding (3 bits);
  - `RV_NOP` = 32'h0000_0013;
  - the IF/ID payload struct {instr, pc}.
- One sub-module, `if_skid_buf`: a 1-entry holding register for {instr, pc} with load/clear/valid.
- FSM, IF/ID register and pc+4 adder stay in `if_stage`.

## Test plan
- Reset then L=1 memory returning 32'h00500093 at `pc`=0 → `imem_req` at cycle 1, `id_valid`=1, `id_instr`=32'h00500093, `id_pc`=0, `id_pc_4`=4 at cycle 3, single `pc_advance` pulse at cycle 2.
- L=3 memory, 4 instructions → `imem_req` spacing 4 cycles, `id_pc` sequence 0,4,8,C, no duplicate or missing fetch.
- `id_stall`=1 for 5 cycles while a response arrives → FULL, `pc_advance`=0 throughout; on release the skid word enters IF/ID, one `pc_advance` pulse, nothing lost.
- `flush` in WAIT, L=2, `pc` redirected to 32'h40 → DRAIN, stale response discarded, `id_valid`=0 / `id_instr`=32'h13, next `imem_addr`=32'h40.
- `flush` in the same cycle as `imem_rvalid`, and `flush` in FULL → word dropped, `pc_advance`=0, next state REQ.
- `rst` asserted in WAIT, `imem_rvalid` arrives the cycle after reset releases → ignored. All outputs at reset values. First request at `pc`=0.
